// File: rtl/trace_collector_if.sv
`default_nettype none
// ============================================================================
// trace_collector_if : retire-trace capture inputs and FWFT drain bus | Rev 1.0
// ============================================================================
interface trace_collector_if #(
  parameter int DEPTH                    = 8,
  parameter int PC_WIDTH                 = 64,
  parameter int DELTA_WIDTH              = 16,
  parameter int RISC_V_INSTRUCTION_WIDTH = 32
);
  localparam int c_data_w = DELTA_WIDTH + PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;
  localparam int c_cnt_w  = $clog2(DEPTH) + 1;

  logic                                pc_valid;
  logic [PC_WIDTH-1:0]                 pc;
  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
  logic                                drop_instr;
  logic                                en;
  logic                                clear;
  logic                                m_valid;
  logic                                m_ready;
  logic [c_data_w-1:0]                 m_data;
  logic [c_cnt_w-1:0]                  fifo_count;
  logic                                almost_full;
  logic                                overflow;
  logic [15:0]                         lost_cnt;

  modport slave (
    input  pc_valid, pc, instr, drop_instr, en, clear, m_ready,
    output m_valid, m_data, fifo_count, almost_full, overflow, lost_cnt
  );

  modport master (
    output pc_valid, pc, instr, drop_instr, en, clear, m_ready,
    input  m_valid, m_data, fifo_count, almost_full, overflow, lost_cnt
  );
endinterface
`default_nettype wire

// File: rtl/trace_collector.sv
`default_nettype none
// ============================================================================
// trace_collector : retire-trace FWFT FIFO with cycle deltas and loss marking
// Rev 1.0
// ============================================================================
module trace_collector #(
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 64,
  parameter int DELTA_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  trace_collector_if.slave bus
);
  localparam int c_instr_w = 32;
  localparam int c_addr_w  = $clog2(DEPTH);
  localparam int c_cnt_w   = c_addr_w + 1;
  localparam int c_data_w  = DELTA_WIDTH + PC_WIDTH + c_instr_w;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_OVF     = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [c_data_w-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0]    r_wr_ptr;
  logic [c_addr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]     r_count;
  logic [DELTA_WIDTH-1:0] r_delta;
  logic                   r_overflow;
  logic [15:0]            r_lost;

  logic                   w_attempt;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_lose;
  logic [DELTA_WIDTH-1:0] w_delta_wr;

  assign w_attempt = bus.en & bus.pc_valid & ~bus.drop_instr;
  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign w_pop     = (r_count != '0) & bus.m_ready;
  // A full FIFO still takes the item when the head leaves on the same edge.
  assign w_push    = w_attempt & (~w_full | w_pop);
  assign w_lose    = w_attempt & ~w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The first item stored after a loss carries an all-ones delta as a gap marker.
  always_comb begin
    w_state_nxt = r_state;
    w_delta_wr  = r_delta;
    case (r_state)
      S_COLLECT: begin
        if (w_lose) begin
          w_state_nxt = S_OVF;
        end
      end
      S_OVF: begin
        w_delta_wr = '1;
        if (w_push) begin
          w_state_nxt = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
    if (bus.clear) begin
      w_state_nxt = S_COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_delta    <= '0;
      r_overflow <= 1'b0;
      r_lost     <= '0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_delta    <= '0;
      r_overflow <= 1'b0;
      r_lost     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_delta <= DELTA_WIDTH'(1);
      end else if (r_delta != '1) begin
        r_delta <= r_delta + DELTA_WIDTH'(1);
      end
      if (w_lose) begin
        r_overflow <= 1'b1;
        if (r_lost != 16'hFFFF) begin
          r_lost <= r_lost + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !bus.clear) begin
      r_mem[r_wr_ptr] <= {w_delta_wr, bus.pc, bus.instr};
    end
  end

  assign bus.m_valid     = (r_count != '0);
  assign bus.m_data      = r_mem[r_rd_ptr];
  assign bus.fifo_count  = r_count;
  assign bus.almost_full = (r_count >= c_cnt_w'(DEPTH - 2));
  assign bus.overflow    = r_overflow;
  assign bus.lost_cnt    = r_lost;
endmodule
`default_nettype wire

// File: tb/tb_trace_collector.sv
`default_nettype none
// ============================================================================
// tb_trace_collector : directed stimulus with a queue scoreboard on the drain
// Rev 1.0
// ============================================================================
module tb_trace_collector;
  localparam int DEPTH = 8;
  localparam int PC_W  = 64;
  localparam int DW    = 16;
  localparam int IW    = 32;
  localparam int MW    = DW + PC_W + IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  trace_collector_if #(.DEPTH(DEPTH), .PC_WIDTH(PC_W), .DELTA_WIDTH(DW)) bus ();

  trace_collector #(.DEPTH(DEPTH), .PC_WIDTH(PC_W), .DELTA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5ns clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [MW-1:0] q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [15:0] d, input logic [63:0] p, input logic [31:0] ins);
    return {d, p, ins};
  endfunction

  function automatic logic [63:0] pcv(input logic [63:0] base, input int k);
    return base + 64'(4 * k);
  endfunction

  function automatic logic [31:0] insv(input int k);
    return 32'h0000_0013 | (32'(k) << 7);
  endfunction

  task automatic tick(input bit v, input bit drop, input logic [63:0] p, input logic [31:0] ins,
                      input bit rdy, input bit clr);
    @(negedge clk);
    bus.pc_valid   = v;
    bus.drop_instr = drop;
    bus.pc         = p;
    bus.instr      = ins;
    bus.m_ready    = rdy;
    bus.clear      = clr;
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, 1'b0, 64'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic item(input logic [63:0] p, input logic [31:0] ins, input bit rdy);
    tick(1'b1, 1'b0, p, ins, rdy, 1'b0);
  endtask

  // Monitor: every accepted head is checked against the oldest expectation.
  initial begin
    logic [MW-1:0] e;
    forever begin
      @(negedge clk);
      #1ns;
      if (rst_n && bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_item: got 0x%0h, need no item", bus.m_data);
        end else begin
          e = q.pop_front();
          check("m_data", bus.m_data, e);
        end
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_valid   = 1'b0;
    bus.drop_instr = 1'b0;
    bus.pc         = '0;
    bus.instr      = '0;
    bus.en         = 1'b1;
    bus.clear      = 1'b0;
    bus.m_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.m_valid, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_afull", bus.almost_full, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_lost", bus.lost_cnt, 0);
    rst_n = 1'b1;

    // Two kept items, four edges apart, consumer always ready.
    idle(1); idle(1); idle(1);
    item(64'h8000_0000, 32'h0002_9663, 1);
    q.push_back(mk(16'd4, 64'h8000_0000, 32'h0002_9663));
    idle(1);
    check("a_valid1", bus.m_valid, 1);
    check("a_count1", bus.fifo_count, 1);
    idle(1);
    check("a_pulse1_end", bus.m_valid, 0);
    idle(1);
    item(64'h8000_0004, 32'h0000_0067, 1);
    q.push_back(mk(16'd4, 64'h8000_0004, 32'h0000_0067));
    idle(1);
    check("a_valid2", bus.m_valid, 1);

    // Filtered items and disabled capture never enter the FIFO.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, pcv(64'h9000_0000, i), 32'h13, 1'b1, 1'b0);
      check("drop_count", bus.fifo_count, 0);
      check("drop_valid", bus.m_valid, 0);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      item(pcv(64'h9100_0000, i), 32'h13, 1);
    end
    idle(1);
    check("en0_count", bus.fifo_count, 0);
    bus.en = 1'b1;

    // Fill with consumer stalled, then lose two items.
    tick(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      item(pcv(64'hA000_0000, k), insv(k), 0);
      q.push_back(mk((k == 0) ? 16'd0 : 16'd1, pcv(64'hA000_0000, k), insv(k)));
      if (k == 5) begin
        check("c_count5", bus.fifo_count, 5);
        check("c_afull5", bus.almost_full, 0);
      end
      if (k == 6) begin
        check("c_count6", bus.fifo_count, 6);
        check("c_afull6", bus.almost_full, 1);
      end
    end
    item(pcv(64'hA000_0000, 8), insv(8), 0);
    check("c_count8", bus.fifo_count, 8);
    check("c_afull8", bus.almost_full, 1);
    check("c_lost0", bus.lost_cnt, 0);
    check("c_ovf0", bus.overflow, 0);
    item(pcv(64'hA000_0000, 9), insv(9), 0);
    check("c_lost1", bus.lost_cnt, 1);
    check("c_ovf1", bus.overflow, 1);
    idle(0);
    check("c_lost2", bus.lost_cnt, 2);
    check("c_count_full", bus.fifo_count, 8);
    check("c_hold_data", bus.m_data, mk(16'd0, 64'hA000_0000, insv(0)));

    // Drain, then the next item is the gap marker.
    repeat (8) idle(1);
    item(64'hB000_0000, 32'h0000_1111, 1);
    q.push_back(mk(16'hFFFF, 64'hB000_0000, 32'h0000_1111));
    check("c_drained", bus.fifo_count, 0);
    check("c_drained_valid", bus.m_valid, 0);
    idle(1);
    check("c_gap_count", bus.fifo_count, 1);
    check("c_ovf_sticky", bus.overflow, 1);
    item(64'hB000_0004, 32'h0000_2222, 1);
    q.push_back(mk(16'd2, 64'hB000_0004, 32'h0000_2222));

    // Three stored items, then clear together with a kept item.
    idle(1);
    item(64'hC000_0000, 32'h0000_3333, 0);
    item(64'hC000_0004, 32'h0000_4444, 0);
    item(64'hC000_0008, 32'h0000_5555, 0);
    tick(1'b1, 1'b0, 64'hC000_000C, 32'h0000_6666, 1'b0, 1'b1);
    check("e_count3", bus.fifo_count, 3);
    check("e_ovf_pre", bus.overflow, 1);
    idle(0);
    check("e_clr_count", bus.fifo_count, 0);
    check("e_clr_valid", bus.m_valid, 0);
    check("e_clr_ovf", bus.overflow, 0);
    check("e_clr_lost", bus.lost_cnt, 0);

    // Full FIFO with simultaneous pop and kept item.
    tick(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      item(pcv(64'hD000_0000, k), insv(k + 16), 0);
      q.push_back(mk((k == 0) ? 16'd0 : 16'd1, pcv(64'hD000_0000, k), insv(k + 16)));
    end
    item(pcv(64'hD000_0000, 8), insv(24), 1);
    q.push_back(mk(16'd1, pcv(64'hD000_0000, 8), insv(24)));
    check("d_count_full", bus.fifo_count, 8);
    idle(0);
    check("d_count_same", bus.fifo_count, 8);
    check("d_lost_same", bus.lost_cnt, 0);
    check("d_ovf_same", bus.overflow, 0);
    repeat (8) idle(1);
    idle(0);
    check("d_drained", bus.fifo_count, 0);

    // Asynchronous reset pulse with five items stored.
    for (int k = 0; k < 5; k++) begin
      item(pcv(64'hE000_0000, k), insv(k + 32), 0);
    end
    idle(0);
    check("f_count5", bus.fifo_count, 5);
    #2ns rst_n = 1'b0;
    #1ns;
    check("f_async_count", bus.fifo_count, 0);
    check("f_async_valid", bus.m_valid, 0);
    #1ns rst_n = 1'b1;
    item(64'hF000_0000, 32'h0000_7777, 1);
    q.push_back(mk(16'd1, 64'hF000_0000, 32'h0000_7777));
    idle(1);
    check("f_post_count", bus.fifo_count, 1);
    idle(1);
    check("f_post_empty", bus.fifo_count, 0);
    check("sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/trace_collector.md
TRACE_COLLECTOR -- requirements
Module: trace_collector

Interface
REQ-001 The block SHALL accept parameter DEPTH, default 8, the FIFO entry count, a power of two and at least 4.
REQ-002 The block SHALL accept parameter PC_WIDTH, default 64, the width of the program counter.
REQ-003 The block SHALL accept parameter DELTA_WIDTH, default 16, the width of the inter-item cycle delta.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-007 The block SHALL have port pc_valid, input, 1 bit: the core retired the instruction on pc/instr this cycle.
REQ-008 The block SHALL have port pc, input, PC_WIDTH bits: the retired instruction address.
REQ-009 The block SHALL have port instr, input, RISC_V_INSTRUCTION_WIDTH bits: the retired instruction word.
REQ-010 The block SHALL have port drop_instr, input, 1 bit: the trace filter verdict for the current cycle, where 1 means discard.
REQ-011 The block SHALL have port en, input, 1 bit: capture enable.
REQ-012 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-013 The block SHALL have port m_valid, output, 1 bit: the head item is available.
REQ-014 The block SHALL have port m_ready, input, 1 bit: the consumer accepts the head item.
REQ-015 The block SHALL have port m_data, output, DELTA_WIDTH+PC_WIDTH+RISC_V_INSTRUCTION_WIDTH bits, packed as {delta, pc, instr} with instr in the LSBs.
REQ-016 The block SHALL have port fifo_count, output, clog2(DEPTH)+1 bits: the number of occupied entries.
REQ-017 The block SHALL have port almost_full, output, 1 bit: asserted when fifo_count >= DEPTH-2.
REQ-018 The block SHALL have port overflow, output, 1 bit: a sticky flag that an item was lost.
REQ-019 The block SHALL have port lost_cnt, output, 16 bits: a saturating count of lost items.

Function
REQ-020 A capture attempt SHALL occur on any rising edge where en=1, pc_valid=1 and drop_instr=0.
REQ-021 A capture attempt SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-022 An accepted capture SHALL write {delta_cnt, pc, instr} at the tail.
REQ-023 A pop SHALL occur on any rising edge where m_valid=1 and m_ready=1.
REQ-024 The FIFO SHALL be first-word-fall-through: m_valid = (fifo_count != 0), and m_data shows the head combinationally from registered storage.
REQ-025 An item accepted at edge N SHALL give m_valid=1 after edge N (one cycle latency); no input-to-output combinational path SHALL exist.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged; when fifo_count=1, the new item becomes the head after the edge.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 delta_cnt SHALL increment by 1 on every edge and saturate at 2^DELTA_WIDTH-1.
REQ-029 delta_cnt SHALL load 1 on an accepted capture, so that the next item's delta equals the number of cycles since the previous accepted item.
REQ-030 A rejected capture (FIFO full, no pop) SHALL be lost.
REQ-031 A lost capture SHALL set overflow=1, increment lost_cnt (saturating at 16'hFFFF), and leave delta_cnt counting.
REQ-032 When en=0, no capture SHALL occur, pops SHALL continue, and delta_cnt SHALL keep counting.
REQ-033 The block SHALL implement state machine COLLECT/OVF.
REQ-034 On the first loss, the state machine SHALL go COLLECT->OVF.
REQ-035 In OVF, captures SHALL still be accepted whenever space exists.
REQ-036 The first item accepted in OVF SHALL carry delta forced to all-ones, as a gap marker.
REQ-037 After accepting that gap-marker item, the state machine SHALL return to COLLECT.
REQ-038 The overflow flag SHALL remain set until clear or reset.
REQ-039 clear=1 SHALL, on the next edge, empty the FIFO, zero the pointers, set delta_cnt=0, overflow=0 and lost_cnt=0, and force the state to COLLECT.
REQ-040 clear SHALL take priority over a simultaneous push or pop; the captured item and the popped head on that edge are discarded.
REQ-041 m_data SHALL hold stable while m_valid=1 and m_ready=0.

Reset
REQ-042 While rst_n=0, the block SHALL asynchronously force m_valid=0, fifo_count=0, almost_full=0, overflow=0, lost_cnt=0, delta_cnt=0, pointers=0 and state=COLLECT.
REQ-043 m_data SHALL be don't-care at reset; FIFO storage SHALL NOT be reset.
REQ-044 Reset SHALL be released synchronously to clk: assertion asynchronous, deassertion sampled on the clock edge.
REQ-045 A reset asserted mid-operation SHALL discard all stored items, with no partial output.

Verification
REQ-046 Reset release, en=1, m_ready=1, with kept items at cycles 3 and 7 (pc=0x80000000, instr=0x00029663; then pc=0x80000004, instr=0x00000067) SHALL produce two m_valid pulses one cycle after each capture, with deltas 4 and 4 respectively, counted from reset release.
REQ-047 pc_valid=1 with drop_instr=1 for 10 cycles SHALL produce fifo_count=0 and m_valid=0 throughout.
REQ-048 m_ready=0 with 8 kept items SHALL give fifo_count=8 and almost_full=1; a 9th and 10th kept item SHALL give lost_cnt=2 and overflow=1.
REQ-049 Continuing REQ-048, with m_ready=1 the 8 original items SHALL drain in order, and the next kept item SHALL carry delta=16'hFFFF.
REQ-050 Full FIFO with m_ready=1 and a kept item on the same edge SHALL keep fifo_count=8 and lost_cnt unchanged.
REQ-051 With 3 items stored, clear=1 together with a kept item SHALL give fifo_count=0, m_valid=0 and overflow=0 on the next cycle.
REQ-052 rst_n pulsed low for 2 ns mid-stream with 5 items stored SHALL immediately give fifo_count=0 and m_valid=0, without waiting for a clock edge.
